snn_timestep_scheduler: RTL and testbench
=========================================

// Module: snn_timestep_scheduler
// PURPOSE
//  Sequences one inference of an N_NEURON array of spiking neurons: clears the
//  array, drives ENCODE_TIME enable steps, applies winner-take-all lateral
//  inhibition and counts spikes per neuron. It then reports the index with the
//  most spikes. Sits between the input-encoder handshake and the classifier
//  output; the neuron array's rst/en/inh pins are driven only by this block.
// PARAMETERS
//  N_NEURON     4   number of neurons controlled (>=2)
//  ENCODE_TIME  23  enable steps per inference (>=1)
//  CNT_W        8   per-neuron spike counter width, saturating
//  INH_CYCLES   1   cycles inh is held after a spike event (>=1)
// PORTS
//  clk           in   1               clock, rising edge
//  rst           in   1               asynchronous active-high reset
//  start_valid   in   1               request to run one inference
//  start_ready   out  1               high only in IDLE; accept = valid&ready
//  neuron_rst    out  1               synchronous clear to neuron array
//  neuron_en     out  1               step enable to neuron array
//  neuron_spike  in   N_NEURON        registered out_spike of each neuron
//  neuron_inh    out  N_NEURON        per-neuron inhibition
//  step_idx      out  $clog2(ENCODE_TIME+1)  current step; 0 outside RUN
//  busy          out  1               high in any state except IDLE
//  result_valid  out  1               winner/count valid, held until accepted
//  result_ready  in   1               consumer accept
//  winner_idx    out  $clog2(N_NEURON) index of max spike count
//  winner_cnt    out  CNT_W           spike count of winner
//  no_spike      out  1               all counters zero at end of inference
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except start_ready=1; counters, inh timers 0.
//  FSM: IDLE -> CLEAR -> RUN -> DRAIN -> ARGMAX -> DONE -> IDLE.
//   IDLE: start_ready=1; on start_valid go CLEAR; counters zeroed on accept.
//   CLEAR: exactly 1 cycle, neuron_rst=1, neuron_en=0.
//   RUN: ENCODE_TIME cycles, neuron_en=1, step_idx counts 1..ENCODE_TIME.
//   DRAIN: 1 cycle, neuron_en=0; samples spikes caused by the last step.
//   ARGMAX: N_NEURON cycles, scans counters index 0..N-1 sequentially.
//   DONE: result_valid=1, outputs stable; on result_ready go IDLE next cycle.
//  Spike sampling: neuron_spike counted only on cycles whose previous cycle had
//   neuron_en=1 (RUN cycles 2..ENCODE_TIME plus DRAIN); all other cycles ignored.
//  Counters: +1 per sampled spike bit; saturate at 2^CNT_W-1, never wrap.
//  Inhibition: if any sampled spike bit is set, every neuron whose bit is 0 gets
//   neuron_inh=1 for the next INH_CYCLES cycles; spiking neurons get 0. A new
//   spike event during an active window restarts the timer with the new mask.
//   neuron_inh forced 0 outside RUN.
//  Argmax: strict greater-than compare; ties resolve to lowest index.
//   no_spike=1 iff the winning count is 0; winner_idx=0 in that case.
//  Latency: accept at cycle 0 -> CLEAR cycle 1 -> RUN cycles 2..ENCODE_TIME+1
//   -> DRAIN -> ARGMAX -> result_valid at cycle ENCODE_TIME+N_NEURON+3.
//  start_valid ignored while busy; result_ready ignored unless in DONE.
//  Async rst mid-inference: immediate return to IDLE, neuron_en/inh drop to 0,
//   result discarded; next inference starts with CLEAR as normal.
// TESTING
//  1 N=4,T=23: start with no spikes -> result_valid at cycle 30, no_spike=1,
//    winner_idx=0, winner_cnt=0; neuron_en high exactly 23 cycles.
//  2 Neuron 2 spikes every 3rd step -> winner_idx=2, winner_cnt=7; while it
//    spikes, neuron_inh=4'b1011 for 1 cycle after each spike.
//  3 Neurons 1 and 3 both spike 5 times -> winner_idx=1 (tie to lowest), cnt=5.
//  4 CNT_W=2, neuron 0 spikes every sampled cycle -> winner_cnt=3 (saturated).
//  5 Assert rst at RUN step 10 -> same cycle neuron_en=0, busy=0, start_ready=1;
//    restart yields result identical to an uninterrupted run.
//  6 Hold result_ready=0 for 5 cycles in DONE -> outputs stable; start_valid
//    pulses ignored; accept then returns to IDLE next cycle.

Source files
------------

// File: rtl/snn_timestep_scheduler.sv
// rtl/snn_timestep_scheduler.sv - inference sequencer for a winner-take-all spiking neuron array
module snn_timestep_scheduler #(
  parameter int N_NEURON    = 4,
  parameter int ENCODE_TIME = 23,
  parameter int CNT_W       = 8,
  parameter int INH_CYCLES  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_valid,
  output logic                             start_ready,
  output logic                             neuron_rst,
  output logic                             neuron_en,
  input  logic [N_NEURON-1:0]              neuron_spike,
  output logic [N_NEURON-1:0]              neuron_inh,
  output logic [$clog2(ENCODE_TIME+1)-1:0] step_idx,
  output logic                             busy,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic [$clog2(N_NEURON)-1:0]      winner_idx,
  output logic [CNT_W-1:0]                 winner_cnt,
  output logic                             no_spike
);

  localparam int STEP_W = $clog2(ENCODE_TIME + 1);
  localparam int IDX_W  = $clog2(N_NEURON);
  localparam int INH_W  = $clog2(INH_CYCLES + 1);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ENCODE_TIME);
  localparam logic [IDX_W-1:0]  SCAN_LAST = IDX_W'(N_NEURON - 1);
  localparam logic [INH_W-1:0]  INH_LOAD  = INH_W'(INH_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_ARGMAX,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [STEP_W-1:0]   step_q;
  logic [IDX_W-1:0]    scan_q;
  logic                en_q;
  logic [CNT_W-1:0]    cnt_q [N_NEURON];
  logic [INH_W-1:0]    inh_timer_q;
  logic [N_NEURON-1:0] inh_mask_q;
  logic [IDX_W-1:0]    best_idx_q;
  logic [CNT_W-1:0]    best_cnt_q;
  logic                accept;
  logic                spike_event;

  assign accept      = start_valid && (state == S_IDLE);
  // spikes are only meaningful one cycle after a step enable
  assign spike_event = en_q && (|neuron_spike);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state and control outputs
  always_comb begin
    state_nxt    = state;
    start_ready  = 1'b0;
    neuron_rst   = 1'b0;
    neuron_en    = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    step_idx     = '0;
    neuron_inh   = '0;
    winner_idx   = '0;
    winner_cnt   = '0;
    no_spike     = 1'b0;
    case (state)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        neuron_rst = 1'b1;
        state_nxt  = S_RUN;
      end
      S_RUN: begin
        neuron_en = 1'b1;
        step_idx  = step_q;
        if (inh_timer_q != '0) neuron_inh = inh_mask_q;
        if (step_q == STEP_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_ARGMAX;
      S_ARGMAX: begin
        if (scan_q == SCAN_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        result_valid = 1'b1;
        winner_idx   = best_idx_q;
        winner_cnt   = best_cnt_q;
        no_spike     = (best_cnt_q == '0);
        if (result_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // step counter runs 1..ENCODE_TIME during RUN; en_q remembers last cycle's enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
      en_q   <= 1'b0;
    end else begin
      en_q <= (state == S_RUN);
      if (state == S_CLEAR)
        step_q <= STEP_W'(1);
      else if (state == S_RUN && step_q != STEP_LAST)
        step_q <= step_q + STEP_W'(1);
    end
  end

  // saturating per-neuron spike counters, zeroed when an inference is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEURON; i++) cnt_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < N_NEURON; i++) cnt_q[i] <= '0;
    end else if (en_q) begin
      for (int i = 0; i < N_NEURON; i++)
        if (neuron_spike[i] && cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  // lateral inhibition window; a new spike event reloads timer and mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inh_timer_q <= '0;
      inh_mask_q  <= '0;
    end else if (accept) begin
      inh_timer_q <= '0;
      inh_mask_q  <= '0;
    end else if (spike_event) begin
      inh_timer_q <= INH_LOAD;
      inh_mask_q  <= ~neuron_spike;
    end else if (inh_timer_q != '0) begin
      inh_timer_q <= inh_timer_q - INH_W'(1);
    end
  end

  // sequential argmax scan; strict compare keeps the lowest index on ties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q     <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
    end else if (state == S_DRAIN) begin
      scan_q     <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
    end else if (state == S_ARGMAX) begin
      scan_q <= scan_q + IDX_W'(1);
      if (cnt_q[scan_q] > best_cnt_q) begin
        best_idx_q <= scan_q;
        best_cnt_q <= cnt_q[scan_q];
      end
    end
  end

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// tb/tb_snn_timestep_scheduler.sv - self-checking bench for snn_timestep_scheduler
module tb_snn_timestep_scheduler;

  localparam int N      = 4;
  localparam int T      = 23;
  localparam int INH    = 1;
  localparam int DONE_R = T + N + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic         neuron_rst;
  logic         neuron_en;
  logic [N-1:0] neuron_spike;
  logic [N-1:0] neuron_inh;
  logic [4:0]   step_idx;
  logic         busy;
  logic         result_valid;
  logic         result_ready;
  logic [1:0]   winner_idx;
  logic [7:0]   winner_cnt;
  logic         no_spike;

  logic         s_start_ready, s_neuron_rst, s_neuron_en, s_busy, s_result_valid, s_no_spike;
  logic [N-1:0] s_neuron_inh;
  logic [4:0]   s_step_idx;
  logic [1:0]   s_winner_idx;
  logic [1:0]   s_winner_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snn_timestep_scheduler #(.N_NEURON(N), .ENCODE_TIME(T), .CNT_W(8), .INH_CYCLES(INH)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .neuron_rst(neuron_rst), .neuron_en(neuron_en), .neuron_spike(neuron_spike),
    .neuron_inh(neuron_inh), .step_idx(step_idx), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
    .winner_idx(winner_idx), .winner_cnt(winner_cnt), .no_spike(no_spike)
  );

  snn_timestep_scheduler #(.N_NEURON(N), .ENCODE_TIME(T), .CNT_W(2), .INH_CYCLES(INH)) dut_sat (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(s_start_ready),
    .neuron_rst(s_neuron_rst), .neuron_en(s_neuron_en), .neuron_spike(neuron_spike),
    .neuron_inh(s_neuron_inh), .step_idx(s_step_idx), .busy(s_busy),
    .result_valid(s_result_valid), .result_ready(result_ready),
    .winner_idx(s_winner_idx), .winner_cnt(s_winner_cnt), .no_spike(s_no_spike)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model: m_r is the cycle number relative to the accept cycle (-1 = idle)
  int           m_r = -1;
  logic [N-1:0] spk_hist [0:63];
  int           m_cnt [N];
  int           s_cnt [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r <= -1;
    end else begin
      if (m_r >= 1 && m_r < 64) spk_hist[m_r] <= neuron_spike;
      if (m_r >= 3 && m_r <= T + 2)
        for (int i = 0; i < N; i++)
          if (neuron_spike[i]) begin
            m_cnt[i] <= (m_cnt[i] + 1 > 255) ? 255 : m_cnt[i] + 1;
            s_cnt[i] <= (s_cnt[i] + 1 > 3) ? 3 : s_cnt[i] + 1;
          end
      if (m_r == -1) begin
        if (start_valid) begin
          m_r <= 1;
          for (int i = 0; i < N; i++) begin
            m_cnt[i] <= 0;
            s_cnt[i] <= 0;
          end
        end
      end else if (m_r == DONE_R) begin
        if (result_ready) m_r <= -1;
      end else begin
        m_r <= m_r + 1;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    logic         en_e;
    logic [N-1:0] inh_e;
    logic         found;
    int           wi, wc, swi, swc;
    en_e  = (m_r >= 2 && m_r <= T + 1);
    inh_e = '0;
    found = 1'b0;
    if (en_e)
      for (int d = 1; d <= INH; d++)
        if (!found && m_r - d >= 3 && spk_hist[m_r-d] != '0) begin
          inh_e = ~spk_hist[m_r-d];
          found = 1'b1;
        end
    chk("start_ready", int'(start_ready), int'(m_r < 1));
    chk("busy", int'(busy), int'(m_r >= 1));
    chk("neuron_rst", int'(neuron_rst), int'(m_r == 1));
    chk("neuron_en", int'(neuron_en), int'(en_e));
    chk("step_idx", int'(step_idx), en_e ? m_r - 1 : 0);
    chk("neuron_inh", int'(neuron_inh), int'(inh_e));
    chk("result_valid", int'(result_valid), int'(m_r == DONE_R));
    chk("sat_result_valid", int'(s_result_valid), int'(m_r == DONE_R));
    if (m_r == DONE_R) begin
      wi = 0; wc = 0; swi = 0; swc = 0;
      for (int i = 0; i < N; i++) begin
        if (m_cnt[i] > wc) begin wc = m_cnt[i]; wi = i; end
        if (s_cnt[i] > swc) begin swc = s_cnt[i]; swi = i; end
      end
      chk("winner_idx", int'(winner_idx), wi);
      chk("winner_cnt", int'(winner_cnt), wc);
      chk("no_spike", int'(no_spike), int'(wc == 0));
      chk("sat_winner_idx", int'(s_winner_idx), swi);
      chk("sat_winner_cnt", int'(s_winner_cnt), swc);
    end
  end

  function automatic logic [N-1:0] pat(input int mode, input int k);
    int s;
    s = k - 1;
    case (mode)
      1: return (s >= 1 && s <= T && s % 3 == 0) ? 4'b0100 : 4'b0000;
      2: begin
        if (k >= 5 && k <= 9) return 4'b0010;
        if (k >= 10 && k <= 18 && k % 2 == 0) return 4'b1000;
        return 4'b0000;
      end
      3: return 4'b0001;
      4: begin
        case (k)
          4, 5: return 4'b0100;
          6:    return 4'b0001;
          7:    return 4'b0101;
          default: return 4'b0000;
        endcase
      end
      default: return 4'b0000;
    endcase
  endfunction

  task automatic run(input int mode, input int hold, input int rst_at,
                     input int exp_idx, input int exp_cnt, input int exp_sat);
    int k;
    int en_cycles;
    bit got;
    bit aborted;
    start_valid  = 1'b1;
    neuron_spike = '0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    en_cycles = 0;
    got = 1'b0;
    aborted = 1'b0;
    k = 1;
    while (k < 100 && !got && !aborted) begin
      neuron_spike = pat(mode, k);
      if (neuron_en) en_cycles++;
      if (mode == 1 && rst_at == 0 && k == 5) chk("inh_after_spike", int'(neuron_inh), 4'b1011);
      if (mode == 1 && rst_at == 0 && k == 6) chk("inh_window_end", int'(neuron_inh), 0);
      if (k == rst_at) begin
        chk("pre_rst_step", int'(step_idx), 10);
        chk("pre_rst_en", int'(neuron_en), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_en_drop", int'(neuron_en), 0);
        chk("rst_busy_drop", int'(busy), 0);
        chk("rst_start_ready", int'(start_ready), 1);
        chk("rst_inh_drop", int'(neuron_inh), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        neuron_spike = '0;
        aborted = 1'b1;
      end else if (result_valid) begin
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    if (!aborted) begin
      chk("result_timeout", int'(got), 1);
      chk("result_latency", k, DONE_R);
      chk("en_cycles", en_cycles, T);
      chk("lit_winner_idx", int'(winner_idx), exp_idx);
      chk("lit_winner_cnt", int'(winner_cnt), exp_cnt);
      chk("lit_no_spike", int'(no_spike), int'(exp_cnt == 0));
      chk("lit_sat_cnt", int'(s_winner_cnt), exp_sat);
      for (int h = 0; h < hold; h++) begin
        start_valid  = h[0];
        result_ready = 1'b0;
        @(posedge clk); #1;
        chk("hold_valid", int'(result_valid), 1);
        chk("hold_idx", int'(winner_idx), exp_idx);
        chk("hold_cnt", int'(winner_cnt), exp_cnt);
      end
      start_valid  = 1'b0;
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      chk("accept_idle", int'(start_ready), 1);
      chk("accept_valid_drop", int'(result_valid), 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst          = 1'b1;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    neuron_spike = '0;
    #12;
    chk("rst_start_ready", int'(start_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_en", int'(neuron_en), 0);
    chk("rst_nrst", int'(neuron_rst), 0);
    chk("rst_inh", int'(neuron_inh), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_step", int'(step_idx), 0);
    chk("rst_no_spike", int'(no_spike), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run(0, 0, 0, 0, 0, 0);     // silent array
    run(1, 0, 0, 2, 7, 3);     // neuron 2 every 3rd step
    run(2, 0, 0, 1, 5, 3);     // tie between neurons 1 and 3
    run(3, 0, 0, 0, 23, 3);    // neuron 0 every sampled cycle
    run(1, 0, 11, 0, 0, 0);    // reset at step 10
    run(1, 0, 0, 2, 7, 3);     // restart after reset
    run(4, 5, 0, 2, 3, 3);     // held result with start pulses

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
